huff_bit_feeder: RTL and testbench

HUFF_BIT_FEEDER -- requirements
Module: huff_bit_feeder

---
 rtl/huff_bit_feeder.sv | 147 ++++++++++++++
 tb/tb_huff_bit_feeder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/huff_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : huff_bit_feeder
// Purpose  : Splits a packed Huffman bitstream (bytes, MSB first) into chunks
//            of up to CHUNK_MAX bits for a downstream decoder. Trailing pad
//            bits of the final byte are dropped. A new byte can be taken in
//            the same cycle as the final chunk of the previous byte, so the
//            decoder sees no gap between bytes.
// Ports    : clk, reset (sync, active low)
//            byte_data/byte_valid/byte_last/byte_pad/byte_ready : byte input
//            out_bits/out_len/out_valid/out_ready                : chunk output
//            busy, done, stream_bits                             : status
// Revision : 1.0 - initial release
// ============================================================================
module huff_bit_feeder #(
  parameter int CHUNK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_last,
  input  logic [2:0]  byte_pad,
  output logic        byte_ready,
  output logic [3:0]  out_bits,
  output logic [2:0]  out_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] stream_bits
);

  localparam logic [3:0] CHUNK_W = 4'(CHUNK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [3:0]  bits_left_q, bits_left_d;
  logic        last_q, last_d;
  logic [15:0] stream_q, stream_d;

  logic [3:0]  chunk_len;
  logic        final_chunk;
  logic [3:0]  load_bits;
  logic [16:0] stream_sum;
  logic [15:0] stream_inc;
  logic        ready_c;

  // Unconsumed bits always sit at the top of byte_q, so the next chunk is
  // contained in the upper nibble.
  assign chunk_len   = (bits_left_q < CHUNK_W) ? bits_left_q : CHUNK_W;
  assign final_chunk = (bits_left_q <= CHUNK_W);
  assign load_bits   = byte_last ? (4'd8 - {1'b0, byte_pad}) : 4'd8;
  assign stream_sum  = {1'b0, stream_q} + {13'd0, chunk_len};
  assign stream_inc  = stream_sum[16] ? 16'hFFFF : stream_sum[15:0];

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    bits_left_d = bits_left_q;
    last_d      = last_q;
    stream_d    = stream_q;
    ready_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (byte_valid) begin
          byte_d      = byte_data;
          bits_left_d = load_bits;
          last_d      = byte_last;
          stream_d    = 16'd0;
          state_d     = ST_FEED;
        end
      end

      ST_FEED: begin
        if (out_ready) begin
          stream_d = stream_inc;
          if (final_chunk) begin
            if (last_q) begin
              byte_d      = 8'd0;
              bits_left_d = 4'd0;
              state_d     = ST_DONE;
            end else begin
              // Refill window: a byte taken here continues the stream.
              ready_c = 1'b1;
              if (byte_valid) begin
                byte_d      = byte_data;
                bits_left_d = load_bits;
                last_d      = byte_last;
              end else begin
                byte_d      = 8'd0;
                bits_left_d = 4'd0;
                state_d     = ST_IDLE;
              end
            end
          end else begin
            byte_d      = byte_q << chunk_len;
            bits_left_d = bits_left_q - chunk_len;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'd0;
      bits_left_q <= 4'd0;
      last_q      <= 1'b0;
      stream_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      bits_left_q <= bits_left_d;
      last_q      <= last_d;
      stream_q    <= stream_d;
    end
  end

  // Status outputs are forced inactive while reset is held.
  assign byte_ready  = ready_c;
  assign out_valid   = reset && (state_q == ST_FEED);
  assign out_len     = out_valid ? chunk_len[2:0] : 3'd0;
  assign out_bits    = out_valid ? (byte_q[7:4] >> (4'd4 - chunk_len)) : 4'd0;
  assign busy        = reset && (state_q != ST_IDLE);
  assign done        = reset && (state_q == ST_DONE);
  assign stream_bits = stream_q;

endmodule
`default_nettype wire

// File: tb/tb_huff_bit_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_huff_bit_feeder
// Purpose  : Directed self-checking bench for huff_bit_feeder. One instance
//            with CHUNK_MAX=4 and one with CHUNK_MAX=3 share the clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_huff_bit_feeder;

  logic clk;
  logic reset;

  // CHUNK_MAX = 4 instance
  logic [7:0]  byte_data;
  logic        byte_valid, byte_last;
  logic [2:0]  byte_pad;
  logic        byte_ready;
  logic [3:0]  out_bits;
  logic [2:0]  out_len;
  logic        out_valid, out_ready;
  logic        busy, done;
  logic [15:0] stream_bits;

  // CHUNK_MAX = 3 instance
  logic [7:0]  b3_data;
  logic        b3_valid, b3_last;
  logic [2:0]  b3_pad;
  logic        b3_ready;
  logic [3:0]  o3_bits;
  logic [2:0]  o3_len;
  logic        o3_valid, o3_ready;
  logic        busy3, done3;
  logic [15:0] stream3;

  int checks = 0;
  int errors = 0;

  huff_bit_feeder #(.CHUNK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_pad(byte_pad), .byte_ready(byte_ready),
    .out_bits(out_bits), .out_len(out_len), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .stream_bits(stream_bits)
  );

  huff_bit_feeder #(.CHUNK_MAX(3)) dut3 (
    .clk(clk), .reset(reset),
    .byte_data(b3_data), .byte_valid(b3_valid), .byte_last(b3_last),
    .byte_pad(b3_pad), .byte_ready(b3_ready),
    .out_bits(o3_bits), .out_len(o3_len), .out_valid(o3_valid),
    .out_ready(o3_ready), .busy(busy3), .done(done3), .stream_bits(stream3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full chunk interface of the CHUNK_MAX=4 instance.
  task automatic chk4(input string tag, input logic v, input logic [3:0] b,
                      input logic [2:0] l, input logic br);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".bits"},  {28'd0, out_bits},  {28'd0, b});
    check({tag, ".len"},   {29'd0, out_len},   {29'd0, l});
    check({tag, ".bready"},{31'd0, byte_ready},{31'd0, br});
  endtask

  initial begin
    reset = 1'b0;
    byte_data = 8'h00; byte_valid = 1'b0; byte_last = 1'b0; byte_pad = 3'd0;
    out_ready = 1'b1;
    b3_data = 8'h00; b3_valid = 1'b0; b3_last = 1'b0; b3_pad = 3'd0;
    o3_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.bits",  {28'd0, out_bits},  32'd0);
    check("rst.len",   {29'd0, out_len},   32'd0);
    check("rst.busy",  {31'd0, busy},      32'd0);
    check("rst.done",  {31'd0, done},      32'd0);
    check("rst.sbits", {16'd0, stream_bits}, 32'd0);
    reset = 1'b1;
    step();
    chk4("idle", 1'b0, 4'h0, 3'd0, 1'b1);
    check("idle.busy", {31'd0, busy}, 32'd0);

    // 0xB5 non-last: 1011 then 0101, refill window on second chunk
    byte_data = 8'hB5; byte_valid = 1'b1; byte_last = 1'b0;
    step();
    byte_valid = 1'b0;
    chk4("b5.c0", 1'b1, 4'hB, 3'd4, 1'b0);
    check("b5.busy", {31'd0, busy}, 32'd1);
    step();
    chk4("b5.c1", 1'b1, 4'h5, 3'd4, 1'b1);
    step();
    chk4("b5.idle", 1'b0, 4'h0, 3'd0, 1'b1);
    check("b5.busy0", {31'd0, busy}, 32'd0);
    check("b5.sbits", {16'd0, stream_bits}, 32'd8);

    // Back-to-back 0x12 then 0x34 (last, pad 0)
    byte_data = 8'h12; byte_valid = 1'b1; byte_last = 1'b0; byte_pad = 3'd0;
    step();
    chk4("bb.c0", 1'b1, 4'h1, 3'd4, 1'b0);
    check("bb.sclr", {16'd0, stream_bits}, 32'd0);
    byte_data = 8'h34; byte_last = 1'b1;
    step();
    chk4("bb.c1", 1'b1, 4'h2, 3'd4, 1'b1);
    step();
    byte_valid = 1'b0;
    chk4("bb.c2", 1'b1, 4'h3, 3'd4, 1'b0);
    check("bb.s8", {16'd0, stream_bits}, 32'd8);
    step();
    chk4("bb.c3", 1'b1, 4'h4, 3'd4, 1'b0);
    step();
    chk4("bb.done", 1'b0, 4'h0, 3'd0, 1'b0);
    check("bb.done1", {31'd0, done}, 32'd1);
    check("bb.busy1", {31'd0, busy}, 32'd1);
    check("bb.s16", {16'd0, stream_bits}, 32'd16);
    step();
    check("bb.done0", {31'd0, done}, 32'd0);
    check("bb.busy0", {31'd0, busy}, 32'd0);
    check("bb.hold", {16'd0, stream_bits}, 32'd16);

    // Last byte 0xE0 pad 5 -> single 3-bit chunk 111
    byte_data = 8'hE0; byte_valid = 1'b1; byte_last = 1'b1; byte_pad = 3'd5;
    step();
    byte_valid = 1'b0;
    chk4("e0.c0", 1'b1, 4'h7, 3'd3, 1'b0);
    step();
    check("e0.done", {31'd0, done}, 32'd1);
    check("e0.sbits", {16'd0, stream_bits}, 32'd3);
    step();

    // Back-pressure: out_ready low for 3 cycles holds the chunk
    byte_data = 8'hA5; byte_valid = 1'b1; byte_last = 1'b0; byte_pad = 3'd0;
    out_ready = 1'b0;
    step();
    byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk4("bp.hold", 1'b1, 4'hA, 3'd4, 1'b0);
      step();
    end
    chk4("bp.still", 1'b1, 4'hA, 3'd4, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.ready0", {31'd0, byte_ready}, 32'd0);
    step();
    chk4("bp.c1", 1'b1, 4'h5, 3'd4, 1'b1);
    step();
    check("bp.sbits", {16'd0, stream_bits}, 32'd8);

    // CHUNK_MAX=3, 0xFF last pad 0 -> lengths 3,3,2
    b3_data = 8'hFF; b3_valid = 1'b1; b3_last = 1'b1; b3_pad = 3'd0;
    step();
    b3_valid = 1'b0;
    check("c3.b0", {28'd0, o3_bits}, 32'h7);
    check("c3.l0", {29'd0, o3_len},  32'd3);
    step();
    check("c3.b1", {28'd0, o3_bits}, 32'h7);
    check("c3.l1", {29'd0, o3_len},  32'd3);
    step();
    check("c3.b2", {28'd0, o3_bits}, 32'h3);
    check("c3.l2", {29'd0, o3_len},  32'd2);
    check("c3.v2", {31'd0, o3_valid}, 32'd1);
    step();
    check("c3.done", {31'd0, done3}, 32'd1);
    check("c3.sbits", {16'd0, stream3}, 32'd8);
    step();

    // Reset pulse mid-FEED discards the byte and clears the count
    byte_data = 8'hB5; byte_valid = 1'b1; byte_last = 1'b0;
    step();
    byte_valid = 1'b0;
    step();
    check("mr.pre", {16'd0, stream_bits}, 32'd4);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk4("mr.post", 1'b0, 4'h0, 3'd0, 1'b1);
    check("mr.busy", {31'd0, busy}, 32'd0);
    check("mr.sbits", {16'd0, stream_bits}, 32'd0);
    step();
    chk4("mr.idle", 1'b0, 4'h0, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
